pe_nic: RTL
===========

Name: pe_nic

Overview:
- Network interface between a processing element (PE) and the PE port of the ring/mesh router.
- Holds one outbound packet (PE to router) and one inbound packet (router to PE), each in a single-entry buffer.
- Injects the outbound packet into the router's pesi/pedi/peri handshake on a matching polarity phase.
- Accepts inbound packets through the router's peso/pedo/pero handshake.
- Exposes both buffers to the PE through a 2-bit-addressed register port.

Parameters:
- PKT_W, 64, packet width in bits.
- VC_BIT, 63, packet bit carrying the virtual-channel/polarity tag.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- addr  in  2  register select: 00 inbound data, 01 inbound status, 10 outbound data, 11 outbound status.
- d_in  in  PKT_W  PE write data.
- d_out  out  PKT_W  PE read data.
- nic_en  in  1  register access enable.
- nic_wr_en  in  1  1 = write, 0 = read; qualified by nic_en.
- polarity  in  1  router polarity_out.
- peri  in  1  router ready to accept an injected packet.
- pesi  out  1  packet valid toward router.
- pedi  out  PKT_W  packet toward router.
- peso  in  1  router delivering a packet.
- pedo  in  PKT_W  packet from router.
- pero  out  1  NIC ready to accept a router packet.

Behaviour:
- Reset (reset == 0 at a posedge):
  - obuf_full = 0, ibuf_full = 0, both buffer data = 0.
  - pesi = 0, pedi = 0.
  - pero is forced to 0 while reset == 0.
  - d_out = 0.
- pero = reset & ~ibuf_full (combinational from registers).
- Outbound write:
  - Condition: nic_en & nic_wr_en & addr == 10 & ~obuf_full, sampled at the edge.
  - Effect: obuf <= d_in, obuf_full <= 1.
  - A write while full is dropped.
  - Writes to 00, 01 and 11 are ignored.
- Injection:
  - Condition: obuf_full & peri & (obuf[VC_BIT] == polarity) at edge k.
  - At edge k: pesi <= 1, pedi <= obuf, obuf_full <= 0.
  - At edge k+1: pesi <= 0, pedi <= 0 (one-cycle pulse).
  - Latency from an accepted write to pesi high: at least 2 edges.
- Same-edge injection and write: the write uses pre-edge obuf_full = 1, so it is dropped. The PE must poll status.
- Receive:
  - Condition: peso & pero at an edge.
  - Effect: ibuf <= pedo, ibuf_full <= 1.
  - peso while pero == 0 is ignored, with no state change.
- Inbound read:
  - Condition: nic_en & ~nic_wr_en & addr == 00.
  - d_out = ibuf combinationally in the same cycle; ibuf_full <= 0 at the edge (destructive read).
  - A read while empty returns the stale data and leaves state unchanged.
- Status reads:
  - addr 01: d_out bit0 = ibuf_full.
  - addr 11: d_out bit0 = obuf_full.
  - All other bits are 0 unless NIC_STATS_EN is defined.
- Read of addr 10 returns obuf with no side effect.
- d_out = 0 whenever nic_en == 0 or nic_wr_en == 1.
- Reset mid-transfer: buffers are discarded, and a pesi pulse in flight is cleared at the reset edge.

Optional Feature:
- Macro: NIC_STATS_EN.
- Defined:
  - 16-bit tx_count increments on each injection edge; 16-bit rx_count increments on each receive edge.
  - Both wrap at 0xFFFF to 0 and clear on reset.
  - Status reads (01 and 11) return rx_count in bits 47:32 and tx_count in bits 31:16.
- Not defined: the counters are absent and those bits read 0.

Decomposition:
- Package nic_pkg:
  - Address constants NIC_ADDR_IBUF = 2'b00, NIC_ADDR_ISTAT = 2'b01, NIC_ADDR_OBUF = 2'b10, NIC_ADDR_OSTAT = 2'b11.
  - PKT_W and VC_BIT.
  - Status field positions.
- Sub-module nic_slot: single-entry buffer with load, clear, data and full signals. Instantiated twice, once for obuf and once for ibuf.

Test Plan:
1. Reset release:
   - During reset: pero = 0, pesi = 0.
   - After the reset edge: pero = 1, and a read of addr 01 or 11 returns 0.
2. Write 0x200200000000FA50 to addr 10 with polarity = 0 and peri = 1 (bit63 = 0):
   - addr 11 reads 1.
   - Next edge: pesi = 1 for exactly one cycle, pedi = 0x200200000000FA50.
   - addr 11 then reads 0.
3. Write 0xC002000000006840 (bit63 = 1) while polarity = 0, with peri = 1:
   - No pesi while polarity stays 0.
   - Toggle polarity to 1: pesi pulses with that packet.
4. Back-to-back writes of 0x2002000000006840 then 0x400200000000FFFF while peri = 0: the second write is dropped, and a later injection carries only 0x2002000000006840.
5. Router delivers 0x400200000000C7D4:
   - peso = 1: ibuf_full = 1 and pero = 0.
   - A second peso with 0x60020000FFFFFFFF is ignored.
   - Read of addr 00 returns 0x400200000000C7D4, then pero = 1.
6. NIC_STATS_EN defined, 3 injections and 2 receives: a read of addr 11 returns bits 31:16 = 3 and bits 47:32 = 2; after reset both read 0.

Source files
------------

// File: rtl/nic_pkg.sv
// Shared definitions for the PE network interface: register map,
// packet geometry and status-word field positions.
// Optional build macro: NIC_STATS_EN (adds injection/receive counters).
package nic_pkg;

    localparam int PKT_W  = 64;
    localparam int VC_BIT = 63;

    localparam logic [1:0] NIC_ADDR_IBUF  = 2'b00;
    localparam logic [1:0] NIC_ADDR_ISTAT = 2'b01;
    localparam logic [1:0] NIC_ADDR_OBUF  = 2'b10;
    localparam logic [1:0] NIC_ADDR_OSTAT = 2'b11;

    // Status word layout: bit 0 is the buffer-full flag; the counter
    // fields are only populated when statistics are compiled in.
    localparam int STAT_FULL_BIT = 0;
    localparam int STAT_TX_LSB   = 16;
    localparam int STAT_RX_LSB   = 32;
    localparam int CNT_W         = 16;

endpackage

// File: rtl/nic_slot.sv
// Single-entry packet buffer. Load captures a packet and marks the slot
// full; clear empties it. The owner never asserts both in one cycle.
module nic_slot #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] load_data,
    output logic [W-1:0] data,
    output logic         full
);

    // Capture on load, release on clear; reset discards the contents.
    always_ff @(posedge clk) begin
        if (!reset) begin
            data <= '0;
            full <= 1'b0;
        end else if (load) begin
            data <= load_data;
            full <= 1'b1;
        end else if (clear) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/pe_nic.sv
// Network interface between a processing element and the router PE port.
// One outbound and one inbound single-entry buffer, exposed to the PE via
// a 2-bit register map. Optional build macro: NIC_STATS_EN adds 16-bit
// tx/rx packet counters reported in the status words.
module pe_nic #(
    parameter int PKT_W  = nic_pkg::PKT_W,
    parameter int VC_BIT = nic_pkg::VC_BIT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       addr,
    input  logic [PKT_W-1:0] d_in,
    output logic [PKT_W-1:0] d_out,
    input  logic             nic_en,
    input  logic             nic_wr_en,
    input  logic             polarity,
    input  logic             peri,
    output logic             pesi,
    output logic [PKT_W-1:0] pedi,
    input  logic             peso,
    input  logic [PKT_W-1:0] pedo,
    output logic             pero
);

    import nic_pkg::*;

    logic [PKT_W-1:0] obuf_data;
    logic             obuf_full;
    logic [PKT_W-1:0] ibuf_data;
    logic             ibuf_full;

    logic pe_read;
    logic obuf_wr;
    logic inject;
    logic recv;
    logic ibuf_rd;

    assign pe_read = nic_en & ~nic_wr_en;
    assign obuf_wr = nic_en & nic_wr_en & (addr == NIC_ADDR_OBUF) & ~obuf_full;
    // Only inject when the packet's VC tag matches the router's current phase.
    assign inject  = obuf_full & peri & (obuf_data[VC_BIT] == polarity);
    assign pero    = reset & ~ibuf_full;
    assign recv    = peso & pero;
    // Empty reads leave state alone, so the clear is qualified by full.
    assign ibuf_rd = pe_read & (addr == NIC_ADDR_IBUF) & ibuf_full;

    nic_slot #(.W(PKT_W)) u_obuf (
        .clk       (clk),
        .reset     (reset),
        .load      (obuf_wr),
        .clear     (inject),
        .load_data (d_in),
        .data      (obuf_data),
        .full      (obuf_full)
    );

    nic_slot #(.W(PKT_W)) u_ibuf (
        .clk       (clk),
        .reset     (reset),
        .load      (recv),
        .clear     (ibuf_rd),
        .load_data (pedo),
        .data      (ibuf_data),
        .full      (ibuf_full)
    );

    // Drive a one-cycle pesi pulse carrying the packet on each injection.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pesi <= 1'b0;
            pedi <= '0;
        end else if (inject) begin
            pesi <= 1'b1;
            pedi <= obuf_data;
        end else begin
            pesi <= 1'b0;
            pedi <= '0;
        end
    end

    logic [PKT_W-1:0] stat_common;

`ifdef NIC_STATS_EN
    logic [CNT_W-1:0] tx_count;
    logic [CNT_W-1:0] rx_count;

    // Count injections and receives; both wrap naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tx_count <= '0;
            rx_count <= '0;
        end else begin
            if (inject) tx_count <= tx_count + 1'b1;
            if (recv)   rx_count <= rx_count + 1'b1;
        end
    end

    // Counter fields shared by both status words.
    always_comb begin
        stat_common = '0;
        stat_common[STAT_TX_LSB +: CNT_W] = tx_count;
        stat_common[STAT_RX_LSB +: CNT_W] = rx_count;
    end
`else
    assign stat_common = '0;
`endif

    // Register read mux; output is zero unless a read is in progress.
    always_comb begin
        d_out = '0;
        if (pe_read) begin
            case (addr)
                NIC_ADDR_IBUF:  d_out = ibuf_data;
                NIC_ADDR_ISTAT: begin
                    d_out = stat_common;
                    d_out[STAT_FULL_BIT] = ibuf_full;
                end
                NIC_ADDR_OBUF:  d_out = obuf_data;
                default: begin
                    d_out = stat_common;
                    d_out[STAT_FULL_BIT] = obuf_full;
                end
            endcase
        end
    end

endmodule
